odo_meas_ctrl: RTL and testbench
================================

Name: odo_meas_ctrl

Overview:
Clocked measurement sequencer that drives the odometer RO array and reads it back. It drives the array's mode and RO-select lines and synchronises the selected, muxed RO output into the clk domain. It counts RO rising edges over a fixed window, first on the reference RO and then on the matching stressed RO. It returns both counts and their signed difference through a valid/ready result handshake. Between measurements it holds the array in sleep or stress mode.

Parameters:
WINDOW_CYCLES, 100, clk cycles per counting window (>=1)
SETTLE_CYCLES, 4, clk cycles after each mode/select change before counting (>=3, covers sync flush)
CNT_W, 16, edge-counter width
SEL_W, 3, RO-select width (8 RO pairs)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request; sampled only in IDLE with no pending result
sel_in  in  SEL_W  RO pair to measure; latched when start is accepted
stress_en  in  1  idle mode: 1 = stress (mode 1), 0 = all sleep (mode 0)
abort  in  1  synchronous abort of an in-flight measurement
ro_in  in  1  muxed RO output from the array; asynchronous to clk
mode  out  2  0 = all sleep, 1 = stressed ROs running, 2 = measure reference, 3 = measure stressed
odo_sel  out  SEL_W  RO select to the array muxes
busy  out  1  high from start acceptance until DONE or abort
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
ref_count  out  CNT_W  reference edge count
str_count  out  CNT_W  stressed edge count
freq_diff  out  CNT_W+1  signed ref_count - str_count
sat  out  1  either counter saturated during this measurement

Behaviour:
- Reset (async, rst_n=0): state IDLE, mode=0, odo_sel=0, busy=0, res_valid=0, all counts and freq_diff=0, sat=0, synchroniser flops=0.
- Idle mode output: mode = stress_en ? 1 : 0. It is registered and follows stress_en with 1 cycle of latency.
- States: IDLE -> SETTLE_R -> MEAS_R -> SETTLE_S -> MEAS_S -> DONE -> IDLE.
- IDLE: start=1 with res_valid=0 latches sel_in into odo_sel, sets busy=1, and moves to SETTLE_R on the next edge.
- SETTLE_R: mode=2. Edge counter cleared. Lasts SETTLE_CYCLES cycles.
- MEAS_R: mode=2. Each synchronised rising edge of ro_in adds 1. Lasts exactly WINDOW_CYCLES cycles. On exit the count goes to ref_count.
- SETTLE_S and MEAS_S mirror the reference phases with mode=3. On exit of MEAS_S the count goes to str_count.
- DONE (1 cycle): freq_diff = ref_count - str_count, sign-extended to CNT_W+1. res_valid set, busy cleared, state to IDLE.
- Latency from the start-accept edge to res_valid=1 is 2*(SETTLE_CYCLES+WINDOW_CYCLES)+1 cycles.
- ro_in sync: 2-flop synchroniser plus 1 history flop. Edge pulse = s2 & ~s3. At most one increment per cycle. Edges arriving faster than clk/2 are undercounted by design.
- Counter saturates at 2^CNT_W-1 and never wraps. Saturation sets sat, which stays set until the next start is accepted.
- Handshake: res_valid stays high and all result outputs stay stable until a cycle with res_valid & res_ready, after which res_valid=0 next cycle. start is ignored while res_valid=1 or busy=1. Back-to-back operation: start on the same cycle as the ready handshake is ignored; it is accepted on the following cycle.
- abort=1 in any non-IDLE state: next state IDLE, busy=0, and mode returns to idle mode. No result is produced and prior result registers are unchanged. abort has priority over phase transitions on the same cycle. abort in IDLE has no effect.
- Reset asserted mid-measurement: immediate return to reset values. No partial result is kept.
- sel_in changes after acceptance have no effect until the next start.

Decomposition:
- Shared package odo_pkg holds:
  - mode encodings MODE_SLEEP=0, MODE_STRESS=1, MODE_MEAS_REF=2, MODE_MEAS_STR=3
  - state enum
  - default WINDOW/SETTLE constants
- Sub-module odo_edge_counter contains synchroniser, edge detect, clear/enable, and saturating CNT_W counter with sat flag. It is instantiated once and shared by both phases.

Test Plan:
- WINDOW=100, SETTLE=4: ro_in has period 4 clk in the ref phase and period 5 clk in the stressed phase -> ref_count=25, str_count=20, freq_diff=+5, sat=0. res_valid rises 209 cycles after the start-accept edge.
- Swap the two periods (5 then 4) -> ref_count=20, str_count=25, freq_diff=-5 (two's complement, all CNT_W+1 bits).
- CNT_W=4, ro_in period 2 -> ref_count=15, sat=1. The counter does not wrap.
- Hold res_ready=0 for 50 cycles after res_valid -> outputs stable and extra start pulses ignored. Raise res_ready -> res_valid=0 next cycle. start one cycle later is accepted.
- abort during MEAS_R -> IDLE, busy=0, mode=stress_en?1:0, previous result unchanged, res_valid stays 0. Also rst_n pulsed during MEAS_S -> all outputs at reset values.
- Idle with stress_en toggling -> mode 0/1 tracks with 1-cycle lag. During a measurement mode shows 2 then 3, and odo_sel equals the sel_in latched at start.

Source files
------------

// File: rtl/odo_pkg.sv
// Shared definitions for the odometer measurement controller.
//   - Array mode encodings driven on the mode lines.
//   - Controller state enum.
//   - Default window/settle lengths and the idle-mode helper.
package odo_pkg;

  localparam logic [1:0] MODE_SLEEP    = 2'd0;
  localparam logic [1:0] MODE_STRESS   = 2'd1;
  localparam logic [1:0] MODE_MEAS_REF = 2'd2;
  localparam logic [1:0] MODE_MEAS_STR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE_R,
    ST_MEAS_R,
    ST_SETTLE_S,
    ST_MEAS_S,
    ST_DONE
  } odo_state_t;

  localparam int DEF_WINDOW_CYCLES = 100;
  localparam int DEF_SETTLE_CYCLES = 4;

  // Mode held on the array between measurements.
  function automatic logic [1:0] idle_mode(input logic stress_en);
    return stress_en ? MODE_STRESS : MODE_SLEEP;
  endfunction

endpackage

// File: rtl/odo_meas_ctrl_if.sv
// Result handshake bundle of the odometer measurement controller.
//   res_valid  : result available (producer -> consumer)
//   res_ready  : consumer accepts result (consumer -> producer)
//   ref_count  : reference RO edge count
//   str_count  : stressed RO edge count
//   freq_diff  : signed ref_count - str_count, CNT_W+1 bits
//   sat        : an edge counter saturated during the measurement
interface odo_meas_ctrl_if #(
  parameter int CNT_W = 16
);
  logic                    res_valid;
  logic                    res_ready;
  logic [CNT_W-1:0]        ref_count;
  logic [CNT_W-1:0]        str_count;
  logic signed [CNT_W:0]   freq_diff;
  logic                    sat;

  modport master (
    output res_valid,
    input  res_ready,
    output ref_count,
    output str_count,
    output freq_diff,
    output sat
  );

  modport slave (
    input  res_valid,
    output res_ready,
    input  ref_count,
    input  str_count,
    input  freq_diff,
    input  sat
  );
endinterface

// File: rtl/odo_edge_counter.sv
// RO edge counter shared by the reference and stressed phases.
//   clk, rst_n : clock, asynchronous active-low reset
//   ro_in      : muxed RO output, asynchronous to clk
//   clr        : clear the count (settle phases)
//   en         : count synchronised rising edges (measure phases)
//   sat_clr    : clear the sticky saturation flag (new measurement)
//   cnt        : registered count
//   cnt_nxt    : count as it will be after this edge (lets the parent
//                capture a window's final increment on its last edge)
//   sat        : sticky, set when the count reaches its ceiling
// Edges faster than clk/2 are undercounted: at most one increment per cycle.
module odo_edge_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ro_in,
  input  logic             clr,
  input  logic             en,
  input  logic             sat_clr,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic ro_sync_p0;
  logic ro_sync_p1;
  logic ro_hist_p2;
  logic rise_p2;
  logic sat_nxt;

  // Increment that sticks at the ceiling instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // p0/p1: two-flop synchroniser; p2: history flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ro_sync_p0 <= 1'b0;
      ro_sync_p1 <= 1'b0;
      ro_hist_p2 <= 1'b0;
    end else begin
      ro_sync_p0 <= ro_in;
      ro_sync_p1 <= ro_sync_p0;
      ro_hist_p2 <= ro_sync_p1;
    end
  end

  assign rise_p2 = ro_sync_p1 & ~ro_hist_p2;

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (en && rise_p2) begin
      cnt_nxt = sat_inc(cnt);
    end

    sat_nxt = sat;
    if (sat_clr) begin
      sat_nxt = 1'b0;
    end else if (en && (cnt_nxt == CNT_MAX)) begin
      sat_nxt = 1'b1;
    end
  end

  // counter / saturation register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sat <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      sat <= sat_nxt;
    end
  end

endmodule

// File: rtl/odo_meas_ctrl.sv
// Odometer measurement sequencer.
// Drives the RO array mode/select lines, counts synchronised RO rising edges
// over a fixed window on the reference RO and then on the matching stressed
// RO, and returns both counts plus their signed difference on a valid/ready
// result bundle. Between measurements the array sits in sleep or stress mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : measurement request, honoured in IDLE with no pending result
//   sel_in     : RO pair to measure, latched on acceptance
//   stress_en  : idle mode select (1 = stress, 0 = sleep)
//   abort      : drop an in-flight measurement without producing a result
//   ro_in      : muxed RO output (asynchronous)
//   mode       : array mode lines
//   odo_sel    : array RO select
//   busy       : measurement in progress
//   res        : result bundle (odo_meas_ctrl_if.master)
module odo_meas_ctrl
  import odo_pkg::*;
#(
  parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = 16,
  parameter int SEL_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SEL_W-1:0] sel_in,
  input  logic             stress_en,
  input  logic             abort,
  input  logic             ro_in,
  output logic [1:0]       mode,
  output logic [SEL_W-1:0] odo_sel,
  output logic             busy,
  odo_meas_ctrl_if.master  res
);

  localparam int PH_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam logic [PH_W-1:0] SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
  localparam logic [PH_W-1:0] WINDOW_LAST = PH_W'(WINDOW_CYCLES - 1);

  odo_state_t       state_q;
  odo_state_t       state_d;
  logic [PH_W-1:0]  ph_q;
  logic [PH_W-1:0]  ph_d;
  logic [1:0]       mode_d;
  logic             accept;
  logic             latch_ref;
  logic             finish;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_sat;
  logic [CNT_W-1:0] ref_hold;

  // Sign-extended difference of two unsigned counts.
  function automatic logic signed [CNT_W:0] count_diff(input logic [CNT_W-1:0] a,
                                                        input logic [CNT_W-1:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  assign cnt_clr = (state_q == ST_SETTLE_R) || (state_q == ST_SETTLE_S);
  assign cnt_en  = (state_q == ST_MEAS_R)   || (state_q == ST_MEAS_S);

  odo_edge_counter #(
    .CNT_W (CNT_W)
  ) u_edge_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .ro_in   (ro_in),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .sat_clr (accept),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .sat     (cnt_sat)
  );

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    accept    = 1'b0;
    latch_ref = 1'b0;
    finish    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !res.res_valid) begin
          accept  = 1'b1;
          state_d = ST_SETTLE_R;
          ph_d    = SETTLE_LAST;
        end
      end
      ST_SETTLE_R: begin
        if (ph_q == '0) begin
          state_d = ST_MEAS_R;
          ph_d    = WINDOW_LAST;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      ST_MEAS_R: begin
        if (ph_q == '0) begin
          state_d   = ST_SETTLE_S;
          ph_d      = SETTLE_LAST;
          latch_ref = 1'b1;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      ST_SETTLE_S: begin
        if (ph_q == '0) begin
          state_d = ST_MEAS_S;
          ph_d    = WINDOW_LAST;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      ST_MEAS_S: begin
        if (ph_q == '0) begin
          state_d = ST_DONE;
        end else begin
          ph_d = ph_q - PH_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        finish  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort wins over any phase transition; nothing is captured.
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      ph_d      = '0;
      latch_ref = 1'b0;
      finish    = 1'b0;
    end

    case (state_d)
      ST_SETTLE_R, ST_MEAS_R:            mode_d = MODE_MEAS_REF;
      ST_SETTLE_S, ST_MEAS_S, ST_DONE:   mode_d = MODE_MEAS_STR;
      default:                           mode_d = idle_mode(stress_en);
    endcase
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      mode    <= MODE_SLEEP;
      odo_sel <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      mode    <= mode_d;
      if (accept) begin
        odo_sel <= sel_in;
        busy    <= 1'b1;
      end else if (state_d == ST_IDLE) begin
        busy    <= 1'b0;
      end
    end
  end

  // result registers: published together with res_valid so an aborted
  // measurement never disturbs the previous result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_hold      <= '0;
      res.res_valid <= 1'b0;
      res.ref_count <= '0;
      res.str_count <= '0;
      res.freq_diff <= '0;
      res.sat       <= 1'b0;
    end else begin
      if (latch_ref) begin
        ref_hold <= cnt_nxt;
      end
      if (finish) begin
        res.res_valid <= 1'b1;
        res.ref_count <= ref_hold;
        res.str_count <= cnt;
        res.freq_diff <= count_diff(ref_hold, cnt);
        res.sat       <= cnt_sat;
      end else if (res.res_valid && res.res_ready) begin
        res.res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_odo_meas_ctrl.sv
module tb_odo_meas_ctrl;
  localparam int W    = 100;
  localparam int S    = 4;
  localparam int CW   = 5;
  localparam int SW   = 3;
  localparam int L    = 2*S + 2*W + 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [SW-1:0] sel_in;
  logic          stress_en;
  logic          abort;
  logic          ro_in;
  logic [1:0]    mode;
  logic [SW-1:0] odo_sel;
  logic          busy;

  odo_meas_ctrl_if #(.CNT_W(CW)) res_if();

  odo_meas_ctrl #(
    .WINDOW_CYCLES (W),
    .SETTLE_CYCLES (S),
    .CNT_W         (CW),
    .SEL_W         (SW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .sel_in    (sel_in),
    .stress_en (stress_en),
    .abort     (abort),
    .ro_in     (ro_in),
    .mode      (mode),
    .odo_sel   (odo_sel),
    .busy      (busy),
    .res       (res_if.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ref_c;
    int     str_c;
    int     diff;
    bit     sat;
    longint t_valid;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     ready_mode = 0;   // 0 random, 1 held low, 2 held high
  exp_t   exp_q[$];
  exp_t   last_res;
  bit     wave[L];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: owns res_ready, pops expectations when a result appears.
  initial begin
    exp_t cur;
    bit   prev_v;
    bit   prev_r;
    bit   rr;
    prev_v = 1'b0;
    prev_r = 1'b0;
    cur    = '{default: 0};
    res_if.res_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        prev_r = 1'b0;
      end else begin
        if (prev_v && prev_r) begin
          chk("valid_clear_after_handshake", res_if.res_valid, 0);
        end else if (prev_v) begin
          chk("valid_held", res_if.res_valid, 1);
          chk("hold_ref_count", res_if.ref_count, cur.ref_c);
          chk("hold_freq_diff", $signed(res_if.freq_diff), cur.diff);
        end
        if (res_if.res_valid && !prev_v) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=valid expected=no result (cycle %0d)", cyc);
          end else begin
            cur = exp_q.pop_front();
            chk("latency", cyc, cur.t_valid);
            chk("ref_count", res_if.ref_count, cur.ref_c);
            chk("str_count", res_if.str_count, cur.str_c);
            chk("freq_diff", $signed(res_if.freq_diff), cur.diff);
            chk("sat", res_if.sat, cur.sat);
            last_res = cur;
          end
        end
      end
      prev_v = res_if.res_valid;
      case (ready_mode)
        1:       rr = 1'b0;
        2:       rr = 1'b1;
        default: rr = ($urandom_range(0, 2) != 0);
      endcase
      res_if.res_ready = rr;
      prev_r = rr;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_mode"}, mode, 0);
    chk({tag, "_odo_sel"}, odo_sel, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_res_valid"}, res_if.res_valid, 0);
    chk({tag, "_ref_count"}, res_if.ref_count, 0);
    chk({tag, "_str_count"}, res_if.str_count, 0);
    chk({tag, "_freq_diff"}, res_if.freq_diff, 0);
    chk({tag, "_sat"}, res_if.sat, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((res_if.res_valid || busy) && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    if (res_if.res_valid || busy) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy/valid still high expected=idle (cycle %0d)", cyc);
    end
  endtask

  // Called at negedge+1 while idle; start is presented for the next edge.
  task automatic do_meas(input logic [SW-1:0] sel, input int pref, input int pstr,
                         input int ph, input bit se, input int abort_k, input int rst_k);
    exp_t e;
    int   rr = 0;
    int   sr = 0;
    int   p;
    for (int k = 0; k < L; k++) begin
      p = (k < S + W) ? pref : pstr;
      wave[k] = (((k + ph) % p) < ((p + 1) / 2));
    end
    // An edge is seen in a cycle when the two samples taken two and one
    // edges earlier went 0 -> 1.
    for (int i = S; i <= S + W - 1; i++) if (wave[i-1] && !wave[i-2]) rr++;
    for (int i = 2*S + W; i <= 2*S + 2*W - 1; i++) if (wave[i-1] && !wave[i-2]) sr++;
    e.ref_c   = (rr > MAXC) ? MAXC : rr;
    e.str_c   = (sr > MAXC) ? MAXC : sr;
    e.diff    = e.ref_c - e.str_c;
    e.sat     = (rr >= MAXC) || (sr >= MAXC);
    e.t_valid = cyc + 2*(S + W) + 2;
    if (abort_k < 0 && rst_k < 0) exp_q.push_back(e);
    stress_en = se;
    for (int k = 0; k < L; k++) begin
      ro_in  = wave[k];
      start  = (k == 0);
      sel_in = (k == 0) ? sel : SW'($urandom);
      abort  = (k == abort_k);
      if (k == 1) begin
        chk("busy_after_accept", busy, 1);
        chk("odo_sel_latched", odo_sel, sel);
        chk("mode_settle_ref", mode, 2);
      end
      if (k == S + W) chk("mode_meas_ref_end", mode, 2);
      if (k == S + W + 1) chk("mode_settle_str", mode, 3);
      if (k == 2*S + 2*W) begin
        chk("mode_meas_str_end", mode, 3);
        chk("odo_sel_held", odo_sel, sel);
        chk("busy_in_meas", busy, 1);
      end
      if (abort_k >= 0 && k == abort_k + 1) begin
        chk("abort_busy", busy, 0);
        chk("abort_mode", mode, se ? 1 : 0);
        chk("abort_res_valid", res_if.res_valid, 0);
        chk("abort_keep_ref", res_if.ref_count, last_res.ref_c);
        chk("abort_keep_str", res_if.str_count, last_res.str_c);
        chk("abort_keep_diff", $signed(res_if.freq_diff), last_res.diff);
        break;
      end
      if (rst_k >= 0 && k == rst_k) begin
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk); #1;
        rst_n = 1'b1;
        last_res = '{default: 0};
        break;
      end
      @(negedge clk); #1;
    end
    start = 1'b0;
    abort = 1'b0;
    ro_in = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_old;
    rst_n = 1'b0; start = 1'b0; sel_in = '0; stress_en = 1'b0; abort = 1'b0; ro_in = 1'b0;
    last_res = '{default: 0};
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    #1 rst_n = 1'b1;

    // Idle mode follows stress_en one edge later.
    for (int i = 0; i < 6; i++) begin
      exp_old   = stress_en ? 2'd1 : 2'd0;
      stress_en = ~stress_en;
      chk("idle_mode_before_edge", mode, exp_old);
      @(negedge clk);
      chk("idle_mode_after_edge", mode, stress_en ? 1 : 0);
      #1;
    end

    // Directed: +5, -5, saturation.
    do_meas(3'd5, 4, 5, 0, 1'b1, -1, -1); wait_idle();
    do_meas(3'd3, 5, 4, 2, 1'b0, -1, -1); wait_idle();
    do_meas(3'd7, 2, 2, 1, 1'b1, -1, -1); wait_idle();

    // Result held while res_ready stays low; start ignored meanwhile.
    ready_mode = 1;
    @(negedge clk); #1;
    do_meas(3'd1, 6, 3, 0, 1'b0, -1, -1);
    for (int i = 0; i < 50; i++) begin
      start  = i[0];
      sel_in = SW'($urandom);
      @(negedge clk); #1;
      chk("start_ignored_while_valid", busy, 0);
    end
    start = 1'b0;
    ready_mode = 2;
    @(negedge clk); #1;
    start = 1'b1;                 // same cycle as the handshake: ignored
    @(negedge clk); #1;
    start = 1'b0;
    chk("valid_low_after_ready", res_if.res_valid, 0);
    chk("start_on_handshake_ignored", busy, 0);
    ready_mode = 0;
    do_meas(3'd6, 3, 7, 1, 1'b1, -1, -1); wait_idle();

    // Abort during the reference window.
    do_meas(3'd2, 4, 4, 0, 1'b1, S + 50, -1);
    repeat (5) @(negedge clk);
    chk("abort_no_result", res_if.res_valid, 0);
    chk("abort_idle_mode", mode, 1);
    #1;

    // Reset during the stressed window, then a normal run.
    do_meas(3'd4, 4, 5, 0, 1'b0, -1, 2*S + W + 30);
    @(negedge clk); #1;
    do_meas(3'd0, 5, 5, 3, 1'b0, -1, -1); wait_idle();

    // Randomised transactions.
    for (int t = 0; t < 6; t++) begin
      int pr;
      int ps;
      pr = $urandom_range(2, 9);
      ps = $urandom_range(2, 9);
      do_meas(SW'($urandom), pr, ps, $urandom_range(0, 8), 1'($urandom), -1, -1);
      wait_idle();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
